auto_guesser: RTL and testbench
===============================

AUTO_GUESSER -- requirements
Module: auto_guesser

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1000, cycles to wait for feedback after a guess before flagging a timeout (legal range 2..65535).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse that begins a new round; honoured only in IDLE or DONE.
REQ-005 low  input  1  feedback: last guess below secret.
REQ-006 high  input  1  feedback: last guess above secret.
REQ-007 bingo  input  1  feedback: last guess equals secret.
REQ-008 livesIn  input  2  lives remaining, as reported by the game.
REQ-009 gnum  output  4  current guess, held stable from guessValid until feedback or timeout.
REQ-010 guessValid  output  1  one-cycle pulse when a new or re-issued gnum is presented.
REQ-011 timerOut  output  1  one-cycle pulse when TIMEOUT_CYCLES elapse in WAIT with no feedback.
REQ-012 busy  output  1  high in GUESS and WAIT.
REQ-013 won  output  1  sticky; set on bingo; cleared by start or reset.
REQ-014 lost  output  1  sticky; set on lives exhausted or inconsistent feedback; cleared by start or reset.
REQ-015 guessCount  output  3  guesses issued this round, including re-issues; saturates at 7.

Function
REQ-016 FSM states: IDLE, GUESS, WAIT, DONE; one transition per clk edge.
REQ-017 IDLE/DONE + start: set lo=0, hi=15, guessCount=0, clear won/lost, go to GUESS.
REQ-018 GUESS, livesIn==0 and guessCount!=0: set lost, go to DONE, no guess issued.
REQ-019 GUESS otherwise: gnum=(lo+hi)>>1 computed 5 bits wide; pulse guessValid; guessCount+1 (saturating); clear timeout counter; go to WAIT.
REQ-020 WAIT feedback priority: bingo > high > low; feedback sampled only in WAIT, ignored elsewhere.
REQ-021 WAIT bingo: set won, go to DONE.
REQ-022 WAIT high: if gnum==lo, set lost (inconsistent) and go to DONE; else hi=gnum-1 and go to GUESS.
REQ-023 WAIT low: if gnum==hi, set lost (inconsistent) and go to DONE; else lo=gnum+1 and go to GUESS.
REQ-024 WAIT, no feedback: counter increments; on the cycle it reaches TIMEOUT_CYCLES-1, pulse timerOut and go to GUESS with lo/hi unchanged (same gnum re-issued).
REQ-025 Feedback arriving on the same cycle as the timeout wins; timerOut not pulsed.
REQ-026 Minimum guess-to-guess spacing is 2 cycles (GUESS then WAIT); feedback may arrive the cycle after guessValid.
REQ-027 start while busy is ignored.
REQ-028 gnum holds its last value in IDLE and DONE.

Reset
REQ-029 On reset: state=IDLE, gnum=0, lo=0, hi=15, guessCount=0, timeout counter=0; guessValid, timerOut, busy, won, lost all 0.
REQ-030 Reset asserted mid-round (GUESS or WAIT) abandons the round; outputs take reset values on the next edge.

Structure
REQ-031 FSM state encoding, GUESS_MIN=0, GUESS_MAX=15 and the default TIMEOUT_CYCLES live in the shared game package, alongside the guess-checker's constants.
REQ-032 Timeout counter is one sub-module, turn_timer (inputs clk, reset, clear, enable; output expire pulse; 16-bit).

Verification
REQ-033 Secret 11, bench answers honestly: guesses 7 (low), 11 (bingo) -> won=1, guessCount=2, DONE.
REQ-034 Secret 0: guesses 7, 3, 1 (high each), then 0 (bingo) -> won=1, guessCount=4.
REQ-035 TIMEOUT_CYCLES=8, no feedback: timerOut pulses 8 cycles after the WAIT entry; guessValid re-pulses with gnum=7; guessCount=2.
REQ-036 Bench answers low to 7, 11, 13, 14 and 15 -> at guess 15 with low, lost=1 (inconsistent), DONE.
REQ-037 livesIn driven to 0 after the first high -> next GUESS sets lost=1 with no further guessValid.
REQ-038 Reset asserted in WAIT with bingo on the same cycle -> won=0 and state=IDLE; a start pulse during WAIT has no effect.

Source files
------------

// File: rtl/auto_guesser_pkg.sv
// ============================================================================
// Module      : auto_guesser_pkg
// Description : Shared game constants, FSM state encoding and guess helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package auto_guesser_pkg;

    localparam int NUM_W                  = 4;
    localparam int LIVES_W                = 2;
    localparam int COUNT_W                = 3;
    localparam int TIMER_W                = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

    localparam logic [NUM_W-1:0]   GUESS_MIN  = 4'd0;
    localparam logic [NUM_W-1:0]   GUESS_MAX  = 4'd15;
    localparam logic [LIVES_W-1:0] LIVES_MAX  = 2'd3;
    localparam logic [COUNT_W-1:0] COUNT_SAT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUESS = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Sum is formed 5 bits wide so lo+hi never wraps before halving.
    function automatic logic [NUM_W-1:0] midpoint(input logic [NUM_W-1:0] lo,
                                                  input logic [NUM_W-1:0] hi);
        logic [NUM_W:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[NUM_W:1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/auto_guesser_turn_timer.sv
// ============================================================================
// Module      : turn_timer
// Description : Feedback timeout counter; pulses expire on its final count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_timer
    import auto_guesser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expire = enable && !clear && (count_q == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/auto_guesser.sv
// ============================================================================
// Module      : auto_guesser
// Description : Binary-search player for the 0..15 number guessing game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module auto_guesser
    import auto_guesser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               low,
    input  logic               high,
    input  logic               bingo,
    input  logic [LIVES_W-1:0] livesIn,
    output logic [NUM_W-1:0]   gnum,
    output logic               guessValid,
    output logic               timerOut,
    output logic               busy,
    output logic               won,
    output logic               lost,
    output logic [COUNT_W-1:0] guessCount
);

    state_e             state_q, state_d;
    logic [NUM_W-1:0]   lo_q, lo_d;
    logic [NUM_W-1:0]   hi_q, hi_d;
    logic [NUM_W-1:0]   gnum_q, gnum_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               won_q, won_d;
    logic               lost_q, lost_d;
    logic               valid_q, valid_d;
    logic               tout_q, tout_d;
    logic               busy_q, busy_d;

    logic               any_fb;
    logic               expire;

    assign any_fb = bingo | high | low;

    turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_turn_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != WAIT),
        .enable ((state_q == WAIT) && !any_fb),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        gnum_d  = gnum_q;
        count_d = count_q;
        won_d   = won_q;
        lost_d  = lost_q;
        valid_d = 1'b0;
        tout_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lo_d    = GUESS_MIN;
                    hi_d    = GUESS_MAX;
                    count_d = '0;
                    won_d   = 1'b0;
                    lost_d  = 1'b0;
                    state_d = GUESS;
                end
            end
            GUESS: begin
                // Out of lives only counts once a guess has actually been spent.
                if ((livesIn == '0) && (count_q != '0)) begin
                    lost_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    gnum_d  = midpoint(lo_q, hi_q);
                    valid_d = 1'b1;
                    count_d = (count_q == COUNT_SAT) ? COUNT_SAT : count_q + 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bingo) begin
                    won_d   = 1'b1;
                    state_d = DONE;
                end else if (high) begin
                    if (gnum_q == lo_q) begin
                        lost_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        hi_d    = gnum_q - 1'b1;
                        state_d = GUESS;
                    end
                end else if (low) begin
                    if (gnum_q == hi_q) begin
                        lost_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        lo_d    = gnum_q + 1'b1;
                        state_d = GUESS;
                    end
                end else if (expire) begin
                    tout_d  = 1'b1;
                    state_d = GUESS;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == GUESS) || (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lo_q    <= GUESS_MIN;
            hi_q    <= GUESS_MAX;
            gnum_q  <= '0;
            count_q <= '0;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            gnum_q  <= gnum_d;
            count_q <= count_d;
            won_q   <= won_d;
            lost_q  <= lost_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
        end
    end

    assign gnum       = gnum_q;
    assign guessValid = valid_q;
    assign timerOut   = tout_q;
    assign busy       = busy_q;
    assign won        = won_q;
    assign lost       = lost_q;
    assign guessCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_auto_guesser.sv
// ============================================================================
// Module      : tb_auto_guesser
// Description : Directed self-checking bench with an expected-guess scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_auto_guesser;
    import auto_guesser_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       low;
    logic       high;
    logic       bingo;
    logic [1:0] livesIn;
    logic [3:0] gnum;
    logic       guessValid;
    logic       timerOut;
    logic       busy;
    logic       won;
    logic       lost;
    logic [2:0] guessCount;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    auto_guesser #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .low        (low),
        .high       (high),
        .bingo      (bingo),
        .livesIn    (livesIn),
        .gnum       (gnum),
        .guessValid (guessValid),
        .timerOut   (timerOut),
        .busy       (busy),
        .won        (won),
        .lost       (lost),
        .guessCount (guessCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // fb: 1=low 2=high 3=bingo; held for exactly one sampling edge
    task automatic respond(input int fb);
        low   = (fb == 1);
        high  = (fb == 2);
        bingo = (fb == 3);
        @(negedge clk);
        low   = 1'b0;
        high  = 1'b0;
        bingo = 1'b0;
    endtask

    task automatic expect_guess(input string tag);
        logic seen;
        int   exp;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (guessValid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, {31'd0, seen}, 32'd1);
        if (seen && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check(tag, {28'd0, gnum}, exp);
        end
    endtask

    initial begin
        int n;
        int gv_seen;

        reset   = 1'b1;
        start   = 1'b0;
        low     = 1'b0;
        high    = 1'b0;
        bingo   = 1'b0;
        livesIn = 2'd3;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_gnum",  {28'd0, gnum}, 32'd0);
        check("rst_valid", {31'd0, guessValid}, 32'd0);
        check("rst_tout",  {31'd0, timerOut}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_won",   {31'd0, won}, 32'd0);
        check("rst_lost",  {31'd0, lost}, 32'd0);
        check("rst_count", {29'd0, guessCount}, 32'd0);

        // Secret 11
        pulse_start();
        check("a_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(7);
        expect_guess("a_g1");
        exp_q.push_back(11);
        respond(1);
        expect_guess("a_g2");
        respond(3);
        check("a_won",   {31'd0, won}, 32'd1);
        check("a_lost",  {31'd0, lost}, 32'd0);
        check("a_busy0", {31'd0, busy}, 32'd0);
        check("a_count", {29'd0, guessCount}, 32'd2);
        check("a_state", 32'(dut.state_q), 32'(DONE));

        // Secret 0
        pulse_start();
        check("b_won_clr", {31'd0, won}, 32'd0);
        exp_q.push_back(7);
        expect_guess("b_g1");
        exp_q.push_back(3);
        respond(2);
        expect_guess("b_g2");
        exp_q.push_back(1);
        respond(2);
        expect_guess("b_g3");
        exp_q.push_back(0);
        respond(2);
        expect_guess("b_g4");
        respond(3);
        check("b_won",   {31'd0, won}, 32'd1);
        check("b_count", {29'd0, guessCount}, 32'd4);

        // Timeout with no feedback
        pulse_start();
        exp_q.push_back(7);
        expect_guess("c_g1");
        n       = 0;
        gv_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (guessValid === 1'b1) gv_seen++;
            if (timerOut === 1'b1) begin
                n = i;
                break;
            end
        end
        check("c_tout_cycle", n, 32'd8);
        check("c_no_early_gv", gv_seen, 32'd0);
        exp_q.push_back(7);
        expect_guess("c_reissue");
        check("c_tout_pulse", {31'd0, timerOut}, 32'd0);
        check("c_count", {29'd0, guessCount}, 32'd2);
        respond(3);
        check("c_won", {31'd0, won}, 32'd1);

        // Inconsistent feedback: low on every guess up to 15
        pulse_start();
        exp_q.push_back(7);
        expect_guess("d_g1");
        exp_q.push_back(11);
        respond(1);
        expect_guess("d_g2");
        exp_q.push_back(13);
        respond(1);
        expect_guess("d_g3");
        exp_q.push_back(14);
        respond(1);
        expect_guess("d_g4");
        exp_q.push_back(15);
        respond(1);
        expect_guess("d_g5");
        respond(1);
        check("d_lost",  {31'd0, lost}, 32'd1);
        check("d_won",   {31'd0, won}, 32'd0);
        check("d_busy",  {31'd0, busy}, 32'd0);
        check("d_count", {29'd0, guessCount}, 32'd5);
        check("d_state", 32'(dut.state_q), 32'(DONE));

        // Lives exhausted after the first answer
        pulse_start();
        check("e_lost_clr", {31'd0, lost}, 32'd0);
        exp_q.push_back(7);
        expect_guess("e_g1");
        livesIn = 2'd0;
        respond(2);
        gv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (guessValid === 1'b1) gv_seen++;
        end
        check("e_no_guess", gv_seen, 32'd0);
        check("e_lost",     {31'd0, lost}, 32'd1);
        check("e_count",    {29'd0, guessCount}, 32'd1);
        check("e_gnum_hold", {28'd0, gnum}, 32'd7);
        livesIn = 2'd3;

        // Start ignored while busy, then reset with bingo in WAIT
        pulse_start();
        exp_q.push_back(7);
        expect_guess("f_g1");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("f_busy_kept", {31'd0, busy}, 32'd1);
        check("f_count_kept", {29'd0, guessCount}, 32'd1);
        check("f_state_wait", 32'(dut.state_q), 32'(WAIT));
        reset = 1'b1;
        bingo = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bingo = 1'b0;
        check("f_won",   {31'd0, won}, 32'd0);
        check("f_busy",  {31'd0, busy}, 32'd0);
        check("f_gnum",  {28'd0, gnum}, 32'd0);
        check("f_count", {29'd0, guessCount}, 32'd0);
        check("f_state", 32'(dut.state_q), 32'(IDLE));

        check("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
